// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared types and constants for the response-side command path
package cmd_pkg;
   localparam int TX_BYTE_W = 8;
   localparam int MAX_REQ   = 8;

   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after the last owner
module rr_arbiter
   import cmd_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]           i_valid,
   input  logic [$clog2(MAX_REQ)-1:0] i_last_grant,
   output logic [N_REQ-1:0]           o_grant_oh,
   output logic [$clog2(MAX_REQ)-1:0] o_grant_idx,
   output logic                       o_any
);
   int w_dist;
   int w_best_dist;
   int w_sel;

   // Distance 0 is the requester right after last_grant; the smallest valid distance wins.
   always_comb begin
      w_dist      = 0;
      w_best_dist = N_REQ;
      w_sel       = 0;
      o_grant_oh  = '0;
      for (int j = 0; j < N_REQ; j++) begin
         w_dist = (j + 2 * N_REQ - 1 - int'(i_last_grant)) % N_REQ;
         if (i_valid[j] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_sel       = j;
         end
      end
      o_any       = |i_valid;
      o_grant_idx = $clog2(MAX_REQ)'(w_sel);
      for (int j = 0; j < N_REQ; j++) begin
         o_grant_oh[j] = o_any && (w_sel == j);
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin sharing of one UART byte transmitter
module uart_tx_arbiter
   import cmd_pkg::*;
#(
   parameter int N_REQ         = 2,
   parameter int STALL_TIMEOUT = 1024,
   parameter int CNT_W         = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [N_REQ-1:0]           i_req_valid,
   input  logic [TX_BYTE_W*N_REQ-1:0] i_req_data,
   input  logic [N_REQ-1:0]           i_req_last,
   output logic [N_REQ-1:0]           o_req_ready,
   input  logic                       i_tx_busy,
   input  logic                       i_tx_done,
   output logic                       o_tx_start,
   output logic [TX_BYTE_W-1:0]       o_tx_byte,
   output logic [N_REQ-1:0]           o_grant_oh,
   output logic                       o_busy,
   output logic                       o_pkt_done,
   output logic                       o_abort_err,
   output logic [2:0]                 o_abort_id,
   output logic [CNT_W-1:0]           o_pkt_cnt
);
   localparam int IDX_W   = $clog2(MAX_REQ);
   localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

   arb_state_t           r_state;
   logic [N_REQ-1:0]     r_grant_oh;
   logic [IDX_W-1:0]     r_gidx;
   logic [IDX_W-1:0]     r_last_grant;
   logic [IDX_W-1:0]     r_abort_id;
   logic [STALL_W-1:0]   r_stall_cnt;
   logic [TX_BYTE_W-1:0] r_tx_byte;
   logic                 r_last_flag;
   logic                 r_pkt_done;
   logic                 r_abort_err;
   logic [CNT_W-1:0]     r_pkt_cnt;

   logic [N_REQ-1:0]     w_pick_oh;
   logic [IDX_W-1:0]     w_pick_idx;
   logic                 w_any;
   logic                 w_g_valid;
   logic                 w_g_last;
   logic [TX_BYTE_W-1:0] w_g_data;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .i_valid      (i_req_valid),
      .i_last_grant (r_last_grant),
      .o_grant_oh   (w_pick_oh),
      .o_grant_idx  (w_pick_idx),
      .o_any        (w_any)
   );

   always_comb begin
      w_g_data = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (r_grant_oh[j]) w_g_data = w_g_data | i_req_data[TX_BYTE_W*j +: TX_BYTE_W];
      end
   end

   assign w_g_valid = |(i_req_valid & r_grant_oh);
   assign w_g_last  = |(i_req_last & r_grant_oh);

   // Ready and start are combinational so accept->launch costs a single cycle.
   assign o_req_ready = (r_state == LOAD) ? (i_req_valid & r_grant_oh) : '0;
   assign o_tx_start  = (r_state == START) && !i_tx_busy;
   assign o_tx_byte   = r_tx_byte;
   assign o_grant_oh  = r_grant_oh;
   assign o_busy      = (r_state != IDLE);
   assign o_pkt_done  = r_pkt_done;
   assign o_abort_err = r_abort_err;
   assign o_abort_id  = r_abort_id;
   assign o_pkt_cnt   = r_pkt_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_grant_oh   <= '0;
         r_gidx       <= '0;
         r_last_grant <= IDX_W'(N_REQ - 1);
         r_abort_id   <= '0;
         r_stall_cnt  <= '0;
         r_tx_byte    <= '0;
         r_last_flag  <= 1'b0;
         r_pkt_done   <= 1'b0;
         r_abort_err  <= 1'b0;
         r_pkt_cnt    <= '0;
      end else begin
         r_pkt_done  <= 1'b0;
         r_abort_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant_oh <= w_pick_oh;
                  r_gidx     <= w_pick_idx;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
               if (w_g_valid) begin
                  r_tx_byte   <= w_g_data;
                  r_last_flag <= w_g_last;
                  r_stall_cnt <= '0;
                  r_state     <= START;
               end else if (r_stall_cnt == STALL_LAST) begin
                  r_abort_err  <= 1'b1;
                  r_abort_id   <= r_gidx;
                  r_last_grant <= r_gidx;
                  r_grant_oh   <= '0;
                  r_stall_cnt  <= '0;
                  r_state      <= IDLE;
               end else begin
                  r_stall_cnt <= r_stall_cnt + STALL_W'(1);
               end
            end
            START: begin
               if (!i_tx_busy) r_state <= WAIT;
            end
            WAIT: begin
               if (i_tx_done) begin
                  if (r_last_flag) begin
                     r_pkt_done   <= 1'b1;
                     r_pkt_cnt    <= r_pkt_cnt + CNT_W'(1);
                     r_last_grant <= r_gidx;
                     r_grant_oh   <= '0;
                     r_state      <= IDLE;
                  end else begin
                     r_state <= LOAD;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART byte transmitter between N_REQ byte-stream requesters, for example the command response formatter and the status/error notifier. Arbitration is round-robin and packet-atomic: once a requester is granted, it keeps the transmitter until its last byte has gone out, so packets never interleave on the wire. A stall watchdog aborts a granted packet whose source stops supplying bytes. The block sits between the response-side sources and the UART TX serializer, which runs on the baud_tick domain logic.

Parameters:
N_REQ, 2, number of requesters (2..8)
STALL_TIMEOUT, 1024, cycles LOAD may wait for the next byte before aborting
CNT_W, 16, width of the completed-packet counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset
req_valid  in  N_REQ  per-requester byte valid
req_data  in  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  in  N_REQ  byte is the final byte of its packet
req_ready  out  N_REQ  one-cycle accept strobe to the granted requester
tx_busy  in  1  serializer is shifting a byte
tx_done  in  1  one-cycle pulse when the stop bit completes
tx_start  out  1  one-cycle pulse that launches tx_byte
tx_byte  out  8  byte to the serializer, stable from tx_start until tx_done
grant_oh  out  N_REQ  one-hot owner of the transmitter; 0 when idle
busy  out  1  state != IDLE
pkt_done  out  1  one-cycle pulse when a packet's last byte completes
abort_err  out  1  one-cycle pulse when the watchdog aborts a packet
abort_id  out  3  index of the aborted requester, held until the next abort
pkt_cnt  out  CNT_W  count of completed packets; wraps modulo 2^CNT_W

Behaviour:
- Reset: one clock clk; reset is asynchronous and active-low on rst_n.
  - All outputs are 0 while reset is asserted.
  - Internal state: state=IDLE, last_grant=N_REQ-1 (so requester 0 wins first), stall_cnt=0.
  - Reset mid-packet drops tx_start at once and abandons the packet with no abort_err.
- Requester contract: req_valid/req_data/req_last stay stable until req_ready. The block never asserts req_ready to a requester that is not granted.
- FSM states: IDLE, LOAD, START, WAIT.
- IDLE:
  - When any req_valid is high, pick the first requester with valid set, scanning from last_grant+1 with wrap.
  - Register grant_oh and go to LOAD on the next cycle.
- LOAD:
  - If req_valid[g] is high: req_ready[g]=1 combinationally; latch tx_byte and last_flag from requester g; clear stall_cnt; go to START.
  - If req_valid[g] is low: increment stall_cnt.
  - When stall_cnt reaches STALL_TIMEOUT-1 with valid still low: pulse abort_err, set abort_id=g, set last_grant=g, clear grant_oh, go to IDLE.
- START:
  - When tx_busy is low: tx_start=1 for one cycle, then go to WAIT.
  - When tx_busy is high: hold in START with tx_start low.
- WAIT (waits for tx_done):
  - last_flag=0: go to LOAD.
  - last_flag=1: pulse pkt_done, increment pkt_cnt, set last_grant=g, clear grant_oh, go to IDLE.
- Latency:
  - Valid in IDLE to req_ready: 1 cycle.
  - req_ready to tx_start: 1 cycle when the serializer is free.
  - tx_done to the next req_ready: 1 cycle.
- tx_done outside WAIT is ignored. A tx_done arriving in the same cycle as tx_start is treated as spurious.
- Single requester active: it is re-granted back to back, costing one IDLE cycle between packets.
- Simultaneous valids at IDLE: the round-robin pointer decides. Valids that change while a packet is in progress do not affect the current grant.
- A one-byte packet (req_last set on the first byte) is legal.
- A requester dropping valid in the first LOAD after grant is counted toward the stall timeout like any other gap.

Decomposition:
- Add to cmd_pkg:
  - arb_state_t enum {IDLE, LOAD, START, WAIT}
  - TX_BYTE_W=8
  - MAX_REQ=8
- One sub-module, rr_arbiter: combinational round-robin pick from a valid vector and a last_grant pointer, producing a one-hot grant and its index.
- The FSM, stall counter, byte register and packet counter stay in uart_tx_arbiter.

Test Plan:
- Reset, then only req 0 sends the 3-byte packet 0xA5, 0x5A, 0x0D (last on 0x0D), with the serializer model asserting tx_done 10 cycles after tx_start -> tx_byte sequence A5, 5A, 0D; one pkt_done; pkt_cnt=1; req_ready seen on req 0 only.
- req 0 and req 1 both valid with 2-byte packets, repeated 3 times -> grant order 0, 1, 0, 1, 0, 1; bytes never interleave; pkt_cnt=6.
- STALL_TIMEOUT=16; req 1 sends byte 0x11 with last=0, then drops valid -> abort_err exactly 16 cycles into LOAD; abort_id=1; no pkt_done; next grant goes to req 0 when it is valid.
- tx_busy held high for 20 cycles at the moment START is entered -> tx_start withheld until tx_busy falls, then a single pulse; tx_byte unchanged throughout.
- Assert rst_n low during WAIT of the second byte of a packet -> all outputs 0 immediately, no abort_err; after release, requester 0 is granted first.
- Preload pkt_cnt by sending 65535 one-byte packets, then send one more -> pkt_cnt wraps to 0 and pkt_done pulses.
